serial_right_shifter: RTL
=========================

// Module: serial_right_shifter
//
// PURPOSE
//   Multi-cycle right-shift unit for the 32-bit non-pipelined datapath.
//   It is the companion of the combinational left shift: it implements SRL/SRA
//   for the ALU path by shifting one bit per clock, using a start/done handshake.
//   The control unit stalls the PC while busy is high.
//   Result is held stable after done until the next accepted start.
//
// PARAMETERS
//   WIDTH    32  data width in bits
//   SHAMT_W   5  shift-amount width; must equal clog2(WIDTH)
//
// PORTS
//   clk         in   1        rising-edge clock
//   reset       in   1        asynchronous, active-high reset
//   start       in   1        request a shift; sampled on rising edge of clk
//   arith       in   1        1 = arithmetic (sign fill), 0 = logical (zero fill)
//   data_in     in   WIDTH    operand; captured when start is accepted
//   shamt       in   SHAMT_W  shift amount 0..WIDTH-1; captured with data_in
//   busy        out  1        high while a shift is in progress
//   done        out  1        one-cycle pulse; result is valid
//   result      out  WIDTH    shifted value
//
// BEHAVIOUR
//   Reset (async, any time):
//     - state=IDLE; busy=0, done=0, result=0
//     - any in-flight operation is discarded; no done is produced for it
//   States: IDLE, SHIFT, DONE
//     IDLE:
//       - start=1: latch data_in->result, shamt->count, arith->mode
//       - go to DONE if shamt==0, otherwise go to SHIFT
//     SHIFT: busy=1; every clock:
//       - result <= {fill, result[WIDTH-1:1]}
//       - fill = mode ? result[WIDTH-1] : 0
//       - count <= count-1
//       - go to DONE on the edge where count==1 (the last shift)
//     DONE:
//       - done=1 and busy=0 for exactly one cycle
//       - start=1 here is accepted exactly as in IDLE (back-to-back operation)
//       - otherwise go to IDLE
//   Handshake rules:
//     - start is ignored while in SHIFT
//     - data_in, shamt and arith are don't-care except on the accepting edge
//   Latency:
//     - done is high during the cycle following the (shamt+1)-th rising edge,
//       counting the accepting edge as edge 1
//     - shamt=0 gives done one cycle after start; shamt=31 gives done 32 cycles
//       after start
//   Width rules:
//     - no shamt is out of range (SHAMT_W bits cover 0..WIDTH-1)
//     - the sign bit for SRA is the captured operand MSB, replicated each cycle
//   Outputs are registered; no combinational path from inputs to outputs.
//
// TESTING
//   1. After reset, result=0x00000000, busy=0, done=0; start=0 keeps them there.
//   2. data_in=0x80000000, shamt=4, arith=0 -> result=0x08000000;
//      done pulses once, 4 cycles after the accepting edge;
//      busy is high for 4 cycles.
//   3. data_in=0x80000000, shamt=4, arith=1 -> result=0xF8000000;
//      same timing as scenario 2.
//   4. data_in=0xDEADBEEF, shamt=0 -> result=0xDEADBEEF;
//      done one cycle after start; busy never asserts.
//   5. data_in=0x80000000, shamt=31, arith=1 -> result=0xFFFFFFFF after 32 cycles.
//      Pulse start with data_in=0x1 mid-shift -> the pulse is ignored and the
//      result is unchanged.
//   6. Assert reset during SHIFT of scenario 2 -> outputs 0 immediately, no done.
//      A new start with 0x00000010, shamt=2, arith=0 -> result=0x00000004.
//      Then assert start during DONE with 0x00000008, shamt=3 -> result=0x00000001.

Source files
------------

// File: rtl/serial_right_shifter.sv
// serial_right_shifter: multi-cycle SRL/SRA unit. Shifts the captured operand
// right by one bit per clock under a start/done handshake. busy stalls the
// PC in the control unit; result holds after done until the next accepted start.
module serial_right_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5    // must equal clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               arith,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, done_q;
  logic                 fill;

  // Sign fill is the current MSB; because it is re-inserted every cycle it
  // stays equal to the captured operand MSB for the whole operation.
  assign fill = mode_q & res_q[WIDTH-1];

  // Next-state logic: accept in IDLE or DONE, shift one bit per clock in SHIFT.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          res_d   = data_in;
          cnt_d   = shamt;
          mode_d  = arith;
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        res_d = {fill, res_q[WIDTH-1:1]};
        cnt_d = cnt_q - SHAMT_W'(1);
        // count==1 means this edge performs the last shift
        if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and flag registers; flags are decoded from the next state
  // so busy/done come straight out of flops with no input-to-output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= (state_d == S_SHIFT);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;

endmodule
